gyro_sample_sequencer: RTL

//  Controller between the gyro read FSM and the tilt integrator. Paces sample requests at a fixed rate.

---
 rtl/gyro_pkg.sv | 47 ++++
 rtl/gyro_rate_tick.sv | 37 +++
 rtl/gyro_sample_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/gyro_pkg.sv
// Shared types, state encoding and per-axis correction helpers for the gyro sample sequencer.
package gyro_pkg;

    typedef logic signed [15:0] rate_t;

    typedef struct packed {
        rate_t x;
        rate_t y;
        rate_t z;
    } axis3_t;

    typedef enum logic [2:0] {
        StIdle,
        StCalReq,
        StCalWait,
        StCalFin,
        StRunTick,
        StRunWait,
        StRunOut
    } seq_state_t;

    localparam rate_t RATE_MAX = 16'sh7FFF;
    localparam rate_t RATE_MIN = 16'sh8000;

    // raw - bias computed in 17 bits so the saturation decision is exact.
    function automatic rate_t correct_rate(rate_t raw, rate_t bias);
        logic signed [16:0] diff;
        logic signed [16:0] hi;
        logic signed [16:0] lo;
        diff = {raw[15], raw} - {bias[15], bias};
        hi   = {1'b0, RATE_MAX};
        lo   = {1'b1, RATE_MIN};
        if (diff > hi) return RATE_MAX;
        if (diff < lo) return RATE_MIN;
        return diff[15:0];
    endfunction

    function automatic rate_t apply_deadband(rate_t v, rate_t thr);
        logic signed [16:0] v17;
        logic signed [16:0] t17;
        v17 = {v[15], v};
        t17 = {thr[15], thr};
        if ((v17 <= t17) && (v17 >= -t17)) return '0;
        return v;
    endfunction

endpackage

// File: rtl/gyro_rate_tick.sv
// Fixed-rate sample pacing: one-cycle tick every TICK_DIV enabled cycles, with synchronous clear.
module gyro_rate_tick #(
    parameter int unsigned TICK_DIV = 100_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CntLast) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/gyro_sample_sequencer.sv
// Gyro read / tilt integrator controller: bias calibration, paced sampling, corrected rate output.
// Optional build macro GYRO_DEADBAND_EN zeroes corrected rates with |value| <= DEADBAND.
module gyro_sample_sequencer
    import gyro_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100_000,
    parameter int unsigned CAL_LOG2    = 6,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned DEADBAND    = 4
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  START_CAL,
    output logic  REQ,
    input  logic  VALID,
    input  rate_t RAW_X,
    input  rate_t RAW_Y,
    input  rate_t RAW_Z,
    output rate_t DX,
    output rate_t DY,
    output rate_t DZ,
    output logic  STEP,
    output logic  TILT_RST,
    output logic  CAL_DONE,
    output logic  ERR
);

    localparam int unsigned AccW = 16 + CAL_LOG2;
    localparam int unsigned NW   = CAL_LOG2 + 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [NW-1:0]  NLast  = NW'((1 << CAL_LOG2) - 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYC - 1);

    typedef logic signed [AccW-1:0] acc_t;
    typedef struct packed {
        acc_t x;
        acc_t y;
        acc_t z;
    } acc3_t;

    function automatic acc_t sext(rate_t r);
        return acc_t'(r);
    endfunction

    function automatic rate_t avg(acc_t a);
        acc_t s;
        s = a >>> CAL_LOG2;
        return s[15:0];
    endfunction

    seq_state_t      state_q, state_d;
    logic            req_q, req_d;
    logic            err_q, err_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic [NW-1:0]   n_q, n_d;
    acc3_t           acc_q, acc_d;
    axis3_t          bias_q, bias_d;
    axis3_t          d_q, d_d;
    axis3_t          corr;
    logic            run;
    logic            tick;

    assign run = (state_q == StRunTick) || (state_q == StRunWait) || (state_q == StRunOut);

    gyro_rate_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .CLK (CLK),
        .RST (RST),
        .en  (run),
        .clr (START_CAL || !run),
        .tick(tick)
    );

`ifdef GYRO_DEADBAND_EN
    localparam rate_t DbThr = rate_t'(DEADBAND);
`else
    logic unused_deadband;
    assign unused_deadband = ^DEADBAND;
`endif

    always_comb begin
        corr.x = correct_rate(RAW_X, bias_q.x);
        corr.y = correct_rate(RAW_Y, bias_q.y);
        corr.z = correct_rate(RAW_Z, bias_q.z);
`ifdef GYRO_DEADBAND_EN
        corr.x = apply_deadband(corr.x, DbThr);
        corr.y = apply_deadband(corr.y, DbThr);
        corr.z = apply_deadband(corr.z, DbThr);
`endif
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        err_d    = err_q;
        to_cnt_d = to_cnt_q;
        n_d      = n_q;
        acc_d    = acc_q;
        bias_d   = bias_q;
        d_d      = d_q;

        case (state_q)
            StIdle: begin
            end
            StCalReq: begin
                acc_d    = '0;
                n_d      = '0;
                req_d    = 1'b1;
                to_cnt_d = '0;
                state_d  = StCalWait;
            end
            StCalWait: begin
                if (!req_q) begin
                    // One idle cycle between samples (or after a timeout), then ask again.
                    req_d    = 1'b1;
                    to_cnt_d = '0;
                end else if (VALID) begin
                    acc_d.x = acc_q.x + sext(RAW_X);
                    acc_d.y = acc_q.y + sext(RAW_Y);
                    acc_d.z = acc_q.z + sext(RAW_Z);
                    n_d     = n_q + 1'b1;
                    req_d   = 1'b0;
                    if (n_q == NLast) state_d = StCalFin;
                end else if (to_cnt_q == ToLast) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StCalFin: begin
                bias_d.x = avg(acc_q.x);
                bias_d.y = avg(acc_q.y);
                bias_d.z = avg(acc_q.z);
                state_d  = StRunTick;
            end
            StRunTick: begin
                if (tick) begin
                    req_d    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = StRunWait;
                end
            end
            StRunWait: begin
                // Ticks landing here are dropped; the pacing counter keeps running.
                if (req_q && VALID) begin
                    d_d     = corr;
                    req_d   = 1'b0;
                    state_d = StRunOut;
                end else if (to_cnt_q == ToLast) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = StRunTick;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StRunOut: begin
                if (tick) begin
                    req_d    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = StRunWait;
                end else begin
                    state_d = StRunTick;
                end
            end
            default: state_d = StIdle;
        endcase

        if (START_CAL) begin
            state_d = StCalReq;
            req_d   = 1'b0;
            err_d   = 1'b0;
            acc_d   = acc_q;
            n_d     = n_q;
            bias_d  = bias_q;
            d_d     = d_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            req_q    <= 1'b0;
            err_q    <= 1'b0;
            to_cnt_q <= '0;
            n_q      <= '0;
            acc_q    <= '0;
            bias_q   <= '0;
            d_q      <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            err_q    <= err_d;
            to_cnt_q <= to_cnt_d;
            n_q      <= n_d;
            acc_q    <= acc_d;
            bias_q   <= bias_d;
            d_q      <= d_d;
        end
    end

    assign REQ      = req_q;
    assign STEP     = (state_q == StRunOut);
    assign DX       = d_q.x;
    assign DY       = d_q.y;
    assign DZ       = d_q.z;
    assign CAL_DONE = run;
    assign TILT_RST = !run;
    assign ERR      = err_q;

endmodule
